// File: rtl/gpio_input_conditioner_pkg.sv
// Shared game parameters: button count and fixed bit positions of each player button.
package game_param;

  localparam int NUM_BTN    = 7;

  localparam int BTN_RIGHT  = 0;
  localparam int BTN_LEFT   = 1;
  localparam int BTN_JUMP   = 2;
  localparam int BTN_SQUAT  = 3;
  localparam int BTN_ATTACK = 4;
  localparam int BTN_DEFEND = 5;
  localparam int BTN_SELECT = 6;

endpackage

// File: rtl/gpio_input_conditioner_if.sv
// Game-control side of the input conditioner: frame strobe in, conditioned button state out.
interface gpio_input_conditioner_if #(
  parameter int NUM_BTN = game_param::NUM_BTN
);

  logic               i_frame_tick;
  logic [NUM_BTN-1:0] o_level;
  logic [NUM_BTN-1:0] o_press_pulse;
  logic [NUM_BTN-1:0] o_frame_press;
  logic [NUM_BTN-1:0] o_frame_level;

  // Conditioner side.
  modport master (
    input  i_frame_tick,
    output o_level,
    output o_press_pulse,
    output o_frame_press,
    output o_frame_level
  );

  // Frame-timing / game-controller side.
  modport slave (
    output i_frame_tick,
    input  o_level,
    input  o_press_pulse,
    input  o_frame_press,
    input  o_frame_level
  );

endinterface

// File: rtl/gpio_input_conditioner_btn_debounce.sv
// One button: 2-flop synchroniser, polarity normalisation, stable-count debounce, press pulse.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int ACTIVE_LOW      = 1,
  parameter int CNT_WIDTH       = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_btn,
  output logic o_level,
  output logic o_press_pulse
);

  localparam logic                 RAW_IDLE = (ACTIVE_LOW != 0);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic [1:0]           sync;
  logic                 s;
  logic [CNT_WIDTH-1:0] cnt;

  assign s = sync[1] ^ RAW_IDLE;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      // Synchroniser reloads the released pin value so a held button looks like a fresh press.
      sync          <= {2{RAW_IDLE}};
      cnt           <= '0;
      o_level       <= 1'b0;
      o_press_pulse <= 1'b0;
    end else begin
      sync          <= {sync[0], i_btn};
      o_press_pulse <= 1'b0;
      if (s == o_level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        o_level       <= ~o_level;
        o_press_pulse <= ~o_level;
        cnt           <= '0;
      end else begin
        cnt <= cnt + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/gpio_input_conditioner.sv
// Debounces the raw player buttons and latches presses per render frame for the game controller.
module gpio_input_conditioner #(
  parameter int NUM_BTN         = game_param::NUM_BTN,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [NUM_BTN-1:0]        i_btn,
  gpio_input_conditioner_if.master  bus
);

  localparam int CNT_WIDTH = $clog2(DEBOUNCE_CYCLES + 1);

  logic [NUM_BTN-1:0] level;
  logic [NUM_BTN-1:0] pulse;
  logic [NUM_BTN-1:0] acc;

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .ACTIVE_LOW      (ACTIVE_LOW),
      .CNT_WIDTH       (CNT_WIDTH)
    ) u_debounce (
      .i_clk         (i_clk),
      .i_rst         (i_rst),
      .i_btn         (i_btn[g]),
      .o_level       (level[g]),
      .o_press_pulse (pulse[g])
    );
  end

  assign bus.o_level       = level;
  assign bus.o_press_pulse = pulse;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      acc               <= '0;
      bus.o_frame_press <= '0;
      bus.o_frame_level <= '0;
    end else if (bus.i_frame_tick) begin
      // A pulse landing on the tick is reported now and not carried into the next frame.
      bus.o_frame_press <= acc | pulse;
      bus.o_frame_level <= level;
      acc               <= '0;
    end else begin
      acc <= acc | pulse;
    end
  end

endmodule

// File: tb/tb_gpio_input_conditioner.sv
// Directed bench for gpio_input_conditioner with DEBOUNCE_CYCLES=4, ACTIVE_LOW=1.
module tb_gpio_input_conditioner;

  localparam int NB = 7;

  logic          clk = 1'b0;
  logic          rst;
  logic [NB-1:0] btn;
  int            checks = 0;
  int            errs   = 0;

  gpio_input_conditioner_if #(.NUM_BTN(NB)) gif ();

  gpio_input_conditioner #(
    .NUM_BTN         (NB),
    .DEBOUNCE_CYCLES (4),
    .ACTIVE_LOW      (1)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .i_btn (btn),
    .bus   (gif)
  );

  always #5 clk = ~clk;

  // Advance one active edge; inputs are driven and outputs sampled 1 ns after it.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic frame_tick();
    gif.i_frame_tick = 1'b1;
    cyc();
    gif.i_frame_tick = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    btn = '1;
    gif.i_frame_tick = 1'b0;
    cyc();
    cyc();
    checks++;
    if ({gif.o_level, gif.o_press_pulse, gif.o_frame_press, gif.o_frame_level} !== 28'h0) begin
      errs++;
      $display("FAIL reset_outputs: got %h want 0",
               {gif.o_level, gif.o_press_pulse, gif.o_frame_press, gif.o_frame_level});
    end
    rst = 1'b0;
    for (int n = 0; n < 8; n++) cyc();
    checks++;
    if (gif.o_level !== 7'h00) begin
      errs++;
      $display("FAIL idle_level: got %b want 0000000", gif.o_level);
    end
  endtask

  task automatic test_bouncy_press();
    int pulses = 0;
    int b = game_param::BTN_JUMP;
    logic [1:0] seg_val [5] = '{2'd0, 2'd1, 2'd0, 2'd1, 2'd0};
    int         seg_len [5] = '{2, 1, 2, 1, 0};
    for (int s = 0; s < 4; s++) begin
      btn[b] = seg_val[s][0];
      for (int n = 0; n < seg_len[s]; n++) begin
        cyc();
        checks++;
        if (gif.o_level[b] !== 1'b0) begin
          errs++;
          $display("FAIL bounce_level: seg %0d got %b want 0", s, gif.o_level[b]);
        end
      end
    end
    btn[b] = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      cyc();
      if (gif.o_press_pulse[b] === 1'b1) pulses++;
      checks++;
      if (gif.o_level[b] !== (n >= 6)) begin
        errs++;
        $display("FAIL bouncy_level: cycle %0d got %b want %b", n, gif.o_level[b], (n >= 6));
      end
      checks++;
      if (gif.o_press_pulse[b] !== (n == 6)) begin
        errs++;
        $display("FAIL bouncy_pulse: cycle %0d got %b want %b", n, gif.o_press_pulse[b], (n == 6));
      end
    end
    checks++;
    if (pulses != 1) begin
      errs++;
      $display("FAIL bouncy_pulse_count: got %0d want 1", pulses);
    end
    btn[b] = 1'b1;
    pulses = 0;
    for (int n = 1; n <= 8; n++) begin
      cyc();
      if (gif.o_press_pulse !== 7'h00) pulses++;
    end
    checks++;
    if (pulses != 0 || gif.o_level !== 7'h00) begin
      errs++;
      $display("FAIL release_no_pulse: pulses %0d level %b want 0 / 0000000", pulses, gif.o_level);
    end
  endtask

  task automatic test_short_glitch();
    int bad = 0;
    btn[game_param::BTN_ATTACK] = 1'b0;
    for (int n = 0; n < 3; n++) begin
      cyc();
      if (gif.o_level !== 7'h00 || gif.o_press_pulse !== 7'h00) bad++;
    end
    btn[game_param::BTN_ATTACK] = 1'b1;
    for (int n = 0; n < 10; n++) begin
      cyc();
      if (gif.o_level !== 7'h00 || gif.o_press_pulse !== 7'h00) bad++;
    end
    checks++;
    if (bad != 0) begin
      errs++;
      $display("FAIL short_glitch: got %0d active cycles want 0", bad);
    end
  endtask

  task automatic test_frame_latch();
    frame_tick();
    btn[game_param::BTN_ATTACK] = 1'b0;
    for (int n = 0; n < 8; n++) cyc();
    btn[game_param::BTN_ATTACK] = 1'b1;
    for (int n = 0; n < 8; n++) cyc();
    frame_tick();
    checks++;
    if (gif.o_frame_press !== 7'b0010000) begin
      errs++;
      $display("FAIL frame_press: got %b want 0010000", gif.o_frame_press);
    end
    checks++;
    if (gif.o_frame_level[game_param::BTN_ATTACK] !== 1'b0) begin
      errs++;
      $display("FAIL frame_level4: got %b want 0", gif.o_frame_level[game_param::BTN_ATTACK]);
    end
    for (int n = 0; n < 5; n++) cyc();
    frame_tick();
    checks++;
    if (gif.o_frame_press !== 7'h00) begin
      errs++;
      $display("FAIL frame_press_empty: got %b want 0000000", gif.o_frame_press);
    end
  endtask

  task automatic test_pulse_on_tick();
    int b = game_param::BTN_RIGHT;
    btn[b] = 1'b0;
    for (int n = 0; n < 6; n++) cyc();
    checks++;
    if (gif.o_press_pulse[b] !== 1'b1) begin
      errs++;
      $display("FAIL tick_align_pulse: got %b want 1", gif.o_press_pulse[b]);
    end
    frame_tick();
    checks++;
    if (gif.o_frame_press[b] !== 1'b1 || gif.o_frame_level[b] !== 1'b1) begin
      errs++;
      $display("FAIL tick_coincident: press %b level %b want 1 1",
               gif.o_frame_press[b], gif.o_frame_level[b]);
    end
    for (int n = 0; n < 4; n++) cyc();
    frame_tick();
    checks++;
    if (gif.o_frame_press[b] !== 1'b0 || gif.o_frame_level[b] !== 1'b1) begin
      errs++;
      $display("FAIL tick_next_frame: press %b level %b want 0 1",
               gif.o_frame_press[b], gif.o_frame_level[b]);
    end
    btn[b] = 1'b1;
    for (int n = 0; n < 8; n++) cyc();
  endtask

  task automatic test_reset_mid_count();
    int pulses = 0;
    int b = game_param::BTN_SELECT;
    btn[b] = 1'b0;
    for (int n = 0; n < 4; n++) cyc();
    rst = 1'b1;
    cyc();
    checks++;
    if ({gif.o_level, gif.o_press_pulse, gif.o_frame_press, gif.o_frame_level} !== 28'h0) begin
      errs++;
      $display("FAIL midcount_reset: got %h want 0",
               {gif.o_level, gif.o_press_pulse, gif.o_frame_press, gif.o_frame_level});
    end
    cyc();
    rst = 1'b0;
    for (int n = 1; n <= 9; n++) begin
      cyc();
      if (gif.o_press_pulse[b] === 1'b1) pulses++;
      checks++;
      if (gif.o_level[b] !== (n >= 6)) begin
        errs++;
        $display("FAIL held_level: cycle %0d got %b want %b", n, gif.o_level[b], (n >= 6));
      end
    end
    checks++;
    if (pulses != 1) begin
      errs++;
      $display("FAIL held_pulse_count: got %0d want 1", pulses);
    end
    btn[b] = 1'b1;
    for (int n = 0; n < 8; n++) cyc();
  endtask

  task automatic test_simultaneous();
    frame_tick();
    btn = '0;
    for (int n = 0; n < 6; n++) cyc();
    checks++;
    if (gif.o_press_pulse !== 7'h7F) begin
      errs++;
      $display("FAIL all_pulse: got %h want 7f", gif.o_press_pulse);
    end
    cyc();
    checks++;
    if (gif.o_press_pulse !== 7'h00 || gif.o_level !== 7'h7F) begin
      errs++;
      $display("FAIL all_after: pulse %h level %h want 00 7f", gif.o_press_pulse, gif.o_level);
    end
    frame_tick();
    checks++;
    if (gif.o_frame_press !== 7'h7F || gif.o_frame_level !== 7'h7F) begin
      errs++;
      $display("FAIL all_frame: press %h level %h want 7f 7f", gif.o_frame_press, gif.o_frame_level);
    end
  endtask

  initial begin
    test_reset();
    test_bouncy_press();
    test_short_glitch();
    test_frame_latch();
    test_pulse_on_tick();
    test_reset_mid_count();
    test_simultaneous();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errs);
    $finish;
  end

endmodule
